// File: rtl/axi_4_slave_controller.sv
// AXI-4 slave-side handshake controller.
// Accepts AR/AW addresses and W beats, drives memory read/write strobes with
// per-beat indices, produces RVALID/RLAST and one B response per write burst.
//
// Handshake rule: a transfer happens on a rising clock edge where both valid
// and ready are high. No valid output ever depends on a ready input. Readies
// may depend on same-cycle valids (s_awready on m_arvalid, s_wready on
// m_awvalid), but never the other way around.
module axi_4_slave_controller #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_arvalid,
    input  logic [LEN_W-1:0] m_arlen,
    output logic             s_arready,
    output logic             latch_araddr,
    input  logic             m_rready,
    output logic             s_rvalid,
    output logic             s_rlast,
    output logic             mem_rd_en,
    output logic [LEN_W-1:0] rd_beat_idx,
    input  logic             m_awvalid,
    input  logic [LEN_W-1:0] m_awlen,
    output logic             s_awready,
    output logic             latch_awaddr,
    input  logic             m_wvalid,
    input  logic             m_wlast,
    output logic             s_wready,
    output logic             mem_wr_en,
    output logic [LEN_W-1:0] wr_beat_idx,
    output logic             s_bvalid,
    output logic [1:0]       s_bresp,
    input  logic             m_bready,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        SLAVE_IDLE = 3'd0,
        READ_ISSUE = 3'd1,
        READ_DATA  = 3'd2,
        WRITE_DATA = 3'd3,
        WRITE_RESP = 3'd4
    } state_t;

    localparam logic [LEN_W:0]   CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] RD_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] rd_len;
    logic [LEN_W-1:0] rd_cnt;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W:0]   wr_cnt;     // one extra bit so overlong bursts are seen, not wrapped
    logic             err;
    logic             aw_done;
    logic [1:0]       bresp_q;

    // Beat bookkeeping: in SLAVE_IDLE beat 0 is judged against the incoming awlen
    logic [LEN_W:0]   cur_cnt;
    logic [LEN_W-1:0] cur_len;
    logic             cur_err;
    logic             w_beat;
    logic             beat_over;
    logic             last_bad;
    logic             err_upd;
    logic [LEN_W:0]   cnt_inc;

    // Select the write counter/length/error view for the current state
    always_comb begin
        cur_cnt = wr_cnt;
        cur_len = wr_len;
        cur_err = err;
        if (state == SLAVE_IDLE) begin
            cur_cnt = '0;
            cur_len = m_awlen;
            cur_err = 1'b0;
        end
    end

    assign w_beat    = s_wready & m_wvalid;
    assign beat_over = cur_cnt > {1'b0, cur_len};
    assign last_bad  = m_wlast & (cur_cnt != {1'b0, cur_len});
    assign err_upd   = cur_err | (w_beat & (beat_over | last_bad));
    assign cnt_inc   = (cur_cnt == '1) ? cur_cnt : cur_cnt + CNT_ONE;

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_next   = state;
        s_arready    = 1'b0;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        latch_araddr = 1'b0;
        latch_awaddr = 1'b0;
        s_rvalid     = 1'b0;
        s_rlast      = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        s_bvalid     = 1'b0;
        case (state)
            SLAVE_IDLE: begin
                s_arready = 1'b1;
                s_awready = ~m_arvalid;
                if (m_arvalid) begin
                    latch_araddr = 1'b1;
                    state_next   = READ_ISSUE;
                end else if (m_awvalid) begin
                    latch_awaddr = 1'b1;
                    s_wready     = 1'b1;
                    mem_wr_en    = m_wvalid & ~beat_over;
                    state_next   = (m_wvalid && m_wlast) ? WRITE_RESP : WRITE_DATA;
                end
            end
            READ_ISSUE: begin
                mem_rd_en  = 1'b1;
                state_next = READ_DATA;
            end
            READ_DATA: begin
                s_rvalid = 1'b1;
                s_rlast  = (rd_cnt == rd_len);
                if (m_rready) begin
                    state_next = s_rlast ? SLAVE_IDLE : READ_ISSUE;
                end
            end
            WRITE_DATA: begin
                s_wready  = aw_done;
                mem_wr_en = w_beat & ~beat_over;
                if (w_beat && m_wlast) begin
                    state_next = WRITE_RESP;
                end
            end
            WRITE_RESP: begin
                s_bvalid = 1'b1;
                if (m_bready) begin
                    state_next = SLAVE_IDLE;
                end
            end
            default: state_next = SLAVE_IDLE;
        endcase
    end

    // State register, burst counters, error flag and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SLAVE_IDLE;
            rd_len  <= '0;
            rd_cnt  <= '0;
            wr_len  <= '0;
            wr_cnt  <= '0;
            err     <= 1'b0;
            aw_done <= 1'b0;
            bresp_q <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                SLAVE_IDLE: begin
                    if (m_arvalid) begin
                        rd_len <= m_arlen;
                        rd_cnt <= '0;
                    end else if (m_awvalid) begin
                        wr_len  <= m_awlen;
                        wr_cnt  <= w_beat ? CNT_ONE : '0;
                        aw_done <= 1'b1;
                        err     <= err_upd;
                        if (w_beat && m_wlast) begin
                            bresp_q <= err_upd ? 2'b10 : 2'b00;
                        end
                    end
                end
                READ_DATA: begin
                    if (m_rready && !s_rlast) begin
                        rd_cnt <= rd_cnt + RD_ONE;
                    end
                end
                WRITE_DATA: begin
                    if (w_beat) begin
                        wr_cnt <= cnt_inc;
                        err    <= err_upd;
                        if (m_wlast) begin
                            bresp_q <= err_upd ? 2'b10 : 2'b00;
                        end
                    end
                end
                WRITE_RESP: begin
                    if (m_bready) begin
                        err     <= 1'b0;
                        aw_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_beat_idx = rd_cnt;
    assign wr_beat_idx = cur_cnt[LEN_W-1:0];
    assign s_bresp     = bresp_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_axi_4_slave_controller.sv
// Directed bench for axi_4_slave_controller with a strobe/response scoreboard.
module tb_axi_4_slave_controller;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [LEN_W-1:0] m_arlen, m_awlen;
    logic             s_arready, latch_araddr, s_rvalid, s_rlast, mem_rd_en;
    logic             s_awready, latch_awaddr, s_wready, mem_wr_en, s_bvalid;
    logic [LEN_W-1:0] rd_beat_idx, wr_beat_idx;
    logic [1:0]       s_bresp;
    logic [2:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [LEN_W-1:0] rd_exp_q[$];
    logic [LEN_W-1:0] wr_exp_q[$];
    logic [1:0]       resp_exp_q[$];

    axi_4_slave_controller #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_arlen(m_arlen), .s_arready(s_arready),
        .latch_araddr(latch_araddr), .m_rready(m_rready), .s_rvalid(s_rvalid),
        .s_rlast(s_rlast), .mem_rd_en(mem_rd_en), .rd_beat_idx(rd_beat_idx),
        .m_awvalid(m_awvalid), .m_awlen(m_awlen), .s_awready(s_awready),
        .latch_awaddr(latch_awaddr), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .s_wready(s_wready), .mem_wr_en(mem_wr_en), .wr_beat_idx(wr_beat_idx),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .m_bready(m_bready),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [LEN_W-1:0] obs, input logic [LEN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_arvalid = 1'b0; m_arlen = '0; m_rready = 1'b0;
        m_awvalid = 1'b0; m_awlen = '0; m_wvalid = 1'b0; m_wlast = 1'b0;
        m_bready  = 1'b0;
    endtask

    // Scoreboard: every memory strobe and accepted B response pops an expectation
    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (rd_exp_q.size() == 0) check1("rd_unexpected", mem_rd_en, 1'b0);
            else check8("rd_idx", rd_beat_idx, rd_exp_q.pop_front());
        end
        if (mem_wr_en) begin
            if (wr_exp_q.size() == 0) check1("wr_unexpected", mem_wr_en, 1'b0);
            else check8("wr_idx", wr_beat_idx, wr_exp_q.pop_front());
        end
        if (s_bvalid && m_bready) begin
            if (resp_exp_q.size() == 0) check1("b_unexpected", s_bvalid, 1'b0);
            else check8("bresp", {6'b0, s_bresp}, {6'b0, resp_exp_q.pop_front()});
        end
    end

    initial begin
        // Reset
        reset = 1'b0;
        idle_inputs();
        cyc(); cyc();
        neg();
        check1("rst_arready", s_arready, 1'b1);
        check1("rst_awready", s_awready, 1'b1);
        check1("rst_rvalid", s_rvalid, 1'b0);
        check1("rst_rlast", s_rlast, 1'b0);
        check1("rst_bvalid", s_bvalid, 1'b0);
        check1("rst_wready", s_wready, 1'b0);
        check8("rst_bresp", {6'b0, s_bresp}, 8'd0);
        check8("rst_state", {5'b0, dbg_state}, 8'd0);
        cyc();
        reset = 1'b1;

        // Read arlen=3 at full rate
        cyc();
        for (int i = 0; i < 4; i++) rd_exp_q.push_back(LEN_W'(i));
        m_arvalid = 1'b1; m_arlen = 8'd3; m_rready = 1'b1;
        neg();
        check1("r1_latch", latch_araddr, 1'b1);
        check1("r1_awready", s_awready, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            m_arvalid = 1'b0;
            neg();
            check1("r1_rd_en", mem_rd_en, (c % 2 == 1) && (c <= 7));
            check1("r1_rvalid", s_rvalid, (c % 2 == 0) && (c <= 8));
            check1("r1_rlast", s_rlast, c == 8);
        end
        check1("r1_idle", s_arready, 1'b1);
        m_rready = 1'b0;

        // Read arlen=1 with m_rready low for 3 cycles on beat 0
        cyc();
        rd_exp_q.push_back(8'd0); rd_exp_q.push_back(8'd1);
        m_arvalid = 1'b1; m_arlen = 8'd1;
        neg();
        check1("r2_latch", latch_araddr, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            m_arvalid = 1'b0;
            m_rready = (c >= 5);
            neg();
            check1("r2_rd_en", mem_rd_en, (c == 1) || (c == 6));
            check1("r2_rvalid", s_rvalid, ((c >= 2) && (c <= 5)) || (c == 7));
            check1("r2_rlast", s_rlast, c == 7);
            if (c >= 2 && c <= 5) check8("r2_hold_idx", rd_beat_idx, 8'd0);
        end
        check1("r2_idle", s_arready, 1'b1);
        m_rready = 1'b0;

        // Write awlen=3, four beats, bready delayed two cycles
        cyc();
        for (int i = 0; i < 4; i++) wr_exp_q.push_back(LEN_W'(i));
        resp_exp_q.push_back(2'b00);
        m_awvalid = 1'b1; m_awlen = 8'd3; m_wvalid = 1'b1; m_wlast = 1'b0;
        neg();
        check1("w1_awready", s_awready, 1'b1);
        check1("w1_latch", latch_awaddr, 1'b1);
        check1("w1_wready", s_wready, 1'b1);
        check1("w1_wr_en0", mem_wr_en, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            m_awvalid = 1'b0;
            m_wvalid = (c <= 3);
            m_wlast = (c == 3);
            m_bready = (c == 6);
            neg();
            check1("w1_wr_en", mem_wr_en, c <= 3);
            check1("w1_wready_k", s_wready, c <= 3);
            check1("w1_bvalid", s_bvalid, (c >= 4) && (c <= 6));
            if (c >= 4 && c <= 6) check8("w1_bresp_hold", {6'b0, s_bresp}, 8'd0);
        end
        check1("w1_idle", s_arready, 1'b1);
        m_bready = 1'b0;

        // Write awlen=3 but wlast on beat 1 -> SLVERR
        cyc();
        wr_exp_q.push_back(8'd0); wr_exp_q.push_back(8'd1);
        resp_exp_q.push_back(2'b10);
        m_awvalid = 1'b1; m_awlen = 8'd3; m_wvalid = 1'b1; m_wlast = 1'b0; m_bready = 1'b1;
        neg();
        check1("w2_wr_en0", mem_wr_en, 1'b1);
        cyc();
        m_awvalid = 1'b0; m_wlast = 1'b1;
        neg();
        check1("w2_wr_en1", mem_wr_en, 1'b1);
        cyc();
        m_wvalid = 1'b0; m_wlast = 1'b0;
        neg();
        check1("w2_bvalid", s_bvalid, 1'b1);
        check8("w2_bresp", {6'b0, s_bresp}, 8'h02);
        cyc();
        neg();
        check1("w2_idle", s_arready, 1'b1);
        check1("w2_bvalid_off", s_bvalid, 1'b0);

        // Write awlen=1 with wlast on beat 3 -> beats 2,3 suppressed, SLVERR
        cyc();
        wr_exp_q.push_back(8'd0); wr_exp_q.push_back(8'd1);
        resp_exp_q.push_back(2'b10);
        m_awvalid = 1'b1; m_awlen = 8'd1; m_wvalid = 1'b1; m_wlast = 1'b0;
        neg();
        check1("w3_wr_en0", mem_wr_en, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            m_awvalid = 1'b0;
            m_wvalid = (c <= 3);
            m_wlast = (c == 3);
            neg();
            check1("w3_wr_en", mem_wr_en, c == 1);
            check1("w3_wready", s_wready, c <= 3);
            check1("w3_bvalid", s_bvalid, c == 4);
            if (c == 4) check8("w3_bresp", {6'b0, s_bresp}, 8'h02);
        end
        check1("w3_idle", s_arready, 1'b1);

        // Single-beat write: s_bvalid one cycle after AW, OKAY after a SLVERR burst
        cyc();
        wr_exp_q.push_back(8'd0);
        resp_exp_q.push_back(2'b00);
        m_awvalid = 1'b1; m_awlen = 8'd0; m_wvalid = 1'b1; m_wlast = 1'b1;
        neg();
        check1("w4_wr_en", mem_wr_en, 1'b1);
        cyc();
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_wlast = 1'b0;
        neg();
        check1("w4_bvalid", s_bvalid, 1'b1);
        check8("w4_bresp", {6'b0, s_bresp}, 8'd0);
        cyc();
        neg();
        check1("w4_bvalid_off", s_bvalid, 1'b0);
        m_bready = 1'b0;

        // W data without an address is not accepted
        cyc();
        m_wvalid = 1'b1; m_wlast = 1'b1;
        neg();
        check1("w5_wready", s_wready, 1'b0);
        check1("w5_wr_en", mem_wr_en, 1'b0);
        cyc();
        neg();
        check8("w5_state", {5'b0, dbg_state}, 8'd0);
        m_wvalid = 1'b0; m_wlast = 1'b0;

        // AR and AW together: read wins, write accepted afterwards
        cyc();
        rd_exp_q.push_back(8'd0);
        m_arvalid = 1'b1; m_arlen = 8'd0; m_rready = 1'b1;
        m_awvalid = 1'b1; m_awlen = 8'd0; m_wvalid = 1'b1; m_wlast = 1'b1; m_bready = 1'b1;
        neg();
        check1("c_awready", s_awready, 1'b0);
        check1("c_wready", s_wready, 1'b0);
        check1("c_latch_aw", latch_awaddr, 1'b0);
        check1("c_latch_ar", latch_araddr, 1'b1);
        check1("c_wr_en", mem_wr_en, 1'b0);
        cyc();
        m_arvalid = 1'b0;
        neg();
        check1("c_rd_en", mem_rd_en, 1'b1);
        check1("c_wready_busy", s_wready, 1'b0);
        cyc();
        neg();
        check1("c_rvalid", s_rvalid, 1'b1);
        check1("c_rlast", s_rlast, 1'b1);
        cyc();
        wr_exp_q.push_back(8'd0);
        resp_exp_q.push_back(2'b00);
        neg();
        check1("c_latch_aw2", latch_awaddr, 1'b1);
        check1("c_wr_en2", mem_wr_en, 1'b1);
        cyc();
        m_awvalid = 1'b0; m_wvalid = 1'b0; m_wlast = 1'b0;
        neg();
        check1("c_bvalid", s_bvalid, 1'b1);
        cyc();
        neg();
        check1("c_idle", s_arready, 1'b1);
        idle_inputs();

        // Reset during READ_DATA of beat 2, then a fresh read
        cyc();
        for (int i = 0; i < 3; i++) rd_exp_q.push_back(LEN_W'(i));
        m_arvalid = 1'b1; m_arlen = 8'd3; m_rready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            m_arvalid = 1'b0;
        end
        m_rready = 1'b0;
        check1("x_pre_rvalid", s_rvalid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check1("x_rvalid", s_rvalid, 1'b0);
        check1("x_rlast", s_rlast, 1'b0);
        check1("x_rd_en", mem_rd_en, 1'b0);
        check1("x_bvalid", s_bvalid, 1'b0);
        check1("x_arready", s_arready, 1'b1);
        check1("x_awready", s_awready, 1'b1);
        check8("x_idx", rd_beat_idx, 8'd0);
        cyc();
        reset = 1'b1;
        cyc();
        rd_exp_q.push_back(8'd0);
        m_arvalid = 1'b1; m_arlen = 8'd0; m_rready = 1'b1;
        neg();
        check1("x2_latch", latch_araddr, 1'b1);
        cyc();
        m_arvalid = 1'b0;
        neg();
        check1("x2_rd_en", mem_rd_en, 1'b1);
        check8("x2_idx", rd_beat_idx, 8'd0);
        cyc();
        neg();
        check1("x2_rvalid", s_rvalid, 1'b1);
        check1("x2_rlast", s_rlast, 1'b1);
        cyc();
        neg();
        check1("x2_idle", s_arready, 1'b1);
        idle_inputs();

        // Final report
        cyc();
        check1("rd_q_empty", rd_exp_q.size() == 0, 1'b1);
        check1("wr_q_empty", wr_exp_q.size() == 0, 1'b1);
        check1("resp_q_empty", resp_exp_q.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
